// File: rtl/hq_metric_argmin_pkg.sv
// Shared constants, FSM encoding and metric type for the Hq metric / argmin stage.
package hq_pkg;
  localparam int DEF_Q         = 8;
  localparam int DEF_N         = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int NUM_Q         = 16;
  localparam int ELEMS_PER_Q   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [DEF_ACC_WIDTH-1:0] metric_t;
endpackage

// File: rtl/hq_metric_argmin_if.sv
// Hq element stream in, per-q metrics and argmin result out.
interface hq_metric_argmin_if #(
  parameter int N         = hq_pkg::DEF_N,
  parameter int ACC_WIDTH = hq_pkg::DEF_ACC_WIDTH
);
  logic                  start;
  logic                  Hq_in_valid;
  logic signed [N-1:0]   Hq_in_r;
  logic signed [N-1:0]   Hq_in_i;
  logic                  hq_one_matrix_done;
  logic                  all_16_hq_done;
  logic                  busy;
  logic                  metric_valid;
  logic [3:0]            metric_q;
  logic [ACC_WIDTH-1:0]  metric_out;
  logic                  best_valid;
  logic [3:0]            best_q;
  logic [ACC_WIDTH-1:0]  best_metric;
  logic                  protocol_err;

  modport master (
    output start, Hq_in_valid, Hq_in_r, Hq_in_i, hq_one_matrix_done, all_16_hq_done,
    input  busy, metric_valid, metric_q, metric_out, best_valid, best_q, best_metric,
           protocol_err
  );

  modport slave (
    input  start, Hq_in_valid, Hq_in_r, Hq_in_i, hq_one_matrix_done, all_16_hq_done,
    output busy, metric_valid, metric_q, metric_out, best_valid, best_q, best_metric,
           protocol_err
  );
endinterface

// File: rtl/hq_metric_argmin_cplx_mag_sq.sv
// Registered complex squared magnitude, (r*r + i*i) >>> Q, with valid/last carried alongside.
module cplx_mag_sq #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic signed [N-1:0]  in_r,
  input  logic signed [N-1:0]  in_i,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [2*N-Q:0]       out_sq
);
  logic signed [2*N-1:0] rr;
  logic signed [2*N-1:0] ii;
  logic        [2*N:0]   sum;

  // Squares are non-negative, so zero-extending before the add is safe.
  assign rr  = in_r * in_r;
  assign ii  = in_i * in_i;
  assign sum = {1'b0, rr} + {1'b0, ii};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sq    <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_sq    <= sum[2*N:Q];
    end
  end
endmodule

// File: rtl/hq_metric_argmin.sv
// Per-q ||Hq||^2 accumulation and argmin over 16 codewords.
// Optional framing check enabled by HQ_METRIC_SYNC_CHECK_EN.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_ACCUM | accepting Hq elements for q = 0..15
//   S_FLUSH | last element in pipeline, waiting for the q=15 metric
//   S_DONE  | run complete, waiting for start to drop
module hq_metric_argmin
  import hq_pkg::*;
#(
  parameter int Q         = DEF_Q,
  parameter int N         = DEF_N,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input logic              clk,
  input logic              rst,
  hq_metric_argmin_if.slave bus
);
  localparam int SQ_W = 2*N + 1 - Q;

  state_t                state, state_nx;
  logic [2:0]            elem_cnt;
  logic [3:0]            q_cnt;
  logic [ACC_WIDTH-1:0]  acc, acc_sum;
  logic                  accept, run_start, last_in, final_write;
  logic                  s1_valid, s1_last;
  logic [SQ_W-1:0]       s1_sq;
  logic                  metric_valid_r, best_valid_r;
  logic [3:0]            metric_q_r, best_q_r;
  logic [ACC_WIDTH-1:0]  metric_out_r, best_metric_r;

  assign accept      = bus.Hq_in_valid && (state == S_ACCUM);
  assign run_start   = (state == S_IDLE) && bus.start;
  assign last_in     = (elem_cnt == 3'(ELEMS_PER_Q - 1));
  assign final_write = s1_valid && s1_last && (q_cnt == 4'(NUM_Q - 1));
  assign acc_sum     = acc + ACC_WIDTH'(s1_sq);

  cplx_mag_sq #(.N(N), .Q(Q)) u_mag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_last   (last_in),
    .in_r      (bus.Hq_in_r),
    .in_i      (bus.Hq_in_i),
    .out_valid (s1_valid),
    .out_last  (s1_last),
    .out_sq    (s1_sq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // q_cnt reaches 15 long before the 8th q=15 element arrives, so it is valid here.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_ACCUM;
      S_ACCUM: if (accept && last_in && (q_cnt == 4'(NUM_Q - 1))) state_nx = S_FLUSH;
      S_FLUSH: if (final_write) state_nx = S_DONE;
      S_DONE:  if (!bus.start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt       <= '0;
      q_cnt          <= '0;
      acc            <= '0;
      metric_valid_r <= 1'b0;
      metric_q_r     <= '0;
      metric_out_r   <= '0;
      best_valid_r   <= 1'b0;
      best_q_r       <= '0;
      best_metric_r  <= '1;
    end else begin
      metric_valid_r <= 1'b0;
      best_valid_r   <= metric_valid_r && (metric_q_r == 4'(NUM_Q - 1));
      if (run_start) begin
        elem_cnt      <= '0;
        q_cnt         <= '0;
        acc           <= '0;
        best_q_r      <= '0;
        best_metric_r <= '1;
      end else begin
        if (accept) elem_cnt <= elem_cnt + 3'd1;
        if (s1_valid) begin
          if (s1_last) begin
            acc            <= '0;
            metric_out_r   <= acc_sum;
            metric_q_r     <= q_cnt;
            metric_valid_r <= 1'b1;
            q_cnt          <= q_cnt + 4'd1;
            // Strict compare keeps the lower q on ties.
            if (acc_sum < best_metric_r) begin
              best_metric_r <= acc_sum;
              best_q_r      <= q_cnt;
            end
          end else begin
            acc <= acc_sum;
          end
        end
      end
    end
  end

  assign bus.busy         = (state == S_ACCUM) || (state == S_FLUSH);
  assign bus.metric_valid = metric_valid_r;
  assign bus.metric_q     = metric_q_r;
  assign bus.metric_out   = metric_out_r;
  assign bus.best_valid   = best_valid_r;
  assign bus.best_q       = best_q_r;
  assign bus.best_metric  = best_metric_r;

`ifdef HQ_METRIC_SYNC_CHECK_EN
  logic err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (run_start) begin
      err_r <= 1'b0;
    end else if ((bus.hq_one_matrix_done && bus.Hq_in_valid && !last_in) ||
                 (bus.Hq_in_valid && (state != S_ACCUM)) ||
                 (bus.all_16_hq_done && ((q_cnt != 4'd0) || (state == S_ACCUM)))) begin
      err_r <= 1'b1;
    end
  end

  assign bus.protocol_err = err_r;
`else
  logic unused_done;
  assign unused_done      = bus.hq_one_matrix_done | bus.all_16_hq_done;
  assign bus.protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_hq_metric_argmin.sv
// Directed bench for hq_metric_argmin: single q, reset abort, three full runs, optional framing check.
module tb_hq_metric_argmin;
  import hq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hq_metric_argmin_if #(.N(DEF_N), .ACC_WIDTH(DEF_ACC_WIDTH)) bus ();

  hq_metric_argmin #(.Q(DEF_Q), .N(DEF_N), .ACC_WIDTH(DEF_ACC_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         mcount = 0;
  logic [3:0] mq [0:127];
  metric_t    mv [0:127];
  int         mstamp [0:127];
  int         bcount = 0;
  int         bstamp;
  logic [3:0] bq_seen;
  metric_t    bm_seen;
  int         lastdrv [0:15];

  always @(negedge clk) begin
    if (bus.metric_valid && mcount < 128) begin
      mq[mcount]     = bus.metric_q;
      mv[mcount]     = bus.metric_out;
      mstamp[mcount] = cyc;
      mcount++;
    end
    if (bus.best_valid) begin
      bstamp  = cyc;
      bq_seen = bus.best_q;
      bm_seen = bus.best_metric;
      bcount++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at cycle %0d, required run completion", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  function automatic void get_elem(input int pat, input int q,
                                   output logic signed [15:0] r, output logic signed [15:0] i);
    r = 16'sd128; i = 16'sd0;
    case (pat)
      0: if (q == 9) begin r = 16'sd64; i = 16'sd64; end
      1: if (q == 3 || q == 7) begin r = 16'sd64; i = 16'sd0; end
      default: begin r = -16'sd32768; i = -16'sd32768; end
    endcase
  endfunction

  function automatic metric_t exp_metric(input int pat, input int q);
    case (pat)
      0:       return (q == 9) ? 32'd256 : 32'd512;
      1:       return (q == 3 || q == 7) ? 32'd128 : 32'd512;
      default: return 32'd67108864;
    endcase
  endfunction

  task automatic drive_elem(input logic signed [15:0] r, input logic signed [15:0] i);
    @(negedge clk);
    bus.Hq_in_valid = 1'b1;
    bus.Hq_in_r     = r;
    bus.Hq_in_i     = i;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.Hq_in_valid        = 1'b0;
    bus.hq_one_matrix_done = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_pattern(input int pat, input bit gaps, input bit done_err, output int base);
    logic signed [15:0] r, i;
    int bprev, n;
    base  = mcount;
    bprev = bcount;
    start_run();
    for (int q = 0; q < 16; q++) begin
      for (int e = 0; e < 8; e++) begin
        if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
        get_elem(pat, q, r, i);
        drive_elem(r, i);
        bus.hq_one_matrix_done = done_err && (q == 0) && (e == 5);
        if (e == 7) lastdrv[q] = cyc;
      end
    end
    idle_cycle();
    n = 0;
    while (bcount == bprev && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("best_valid_pulse", bcount, bprev + 1);
  endtask

  task automatic check_run(input int pat, input int base, input logic [3:0] bq, input metric_t bm);
    check("run_metric_count", mcount - base, 16);
    for (int q = 0; q < 16; q++) begin
      check($sformatf("p%0d_metric_q%0d", pat, q), mq[base+q], q);
      check($sformatf("p%0d_metric_out%0d", pat, q), mv[base+q], exp_metric(pat, q));
      check($sformatf("p%0d_latency%0d", pat, q), mstamp[base+q] - lastdrv[q], 2);
    end
    check("best_valid_timing", bstamp - mstamp[base+15], 1);
    check("best_q_pulse", bq_seen, bq);
    check("best_metric_pulse", bm_seen, bm);
    repeat (4) idle_cycle();
    check("best_q_hold", bus.best_q, bq);
    check("best_metric_hold", bus.best_metric, bm);
    check("busy_after_run", bus.busy, 0);
    check("single_best_pulse", bus.best_valid, 0);
  endtask

  initial begin
    int base;
    bus.start = 0; bus.Hq_in_valid = 0; bus.Hq_in_r = 0; bus.Hq_in_i = 0;
    bus.hq_one_matrix_done = 0; bus.all_16_hq_done = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_metric_valid", bus.metric_valid, 0);
    check("rst_metric_out", bus.metric_out, 0);
    check("rst_metric_q", bus.metric_q, 0);
    check("rst_best_valid", bus.best_valid, 0);
    check("rst_best_q", bus.best_q, 0);
    check("rst_best_metric", bus.best_metric, 32'hFFFF_FFFF);
    check("rst_protocol_err", bus.protocol_err, 0);
    rst = 1'b0;

    // Single q=0, then abort with reset after 5 elements of q=4.
    base = mcount;
    start_run();
    check("busy_in_accum", bus.busy, 1);
    for (int e = 0; e < 8; e++) begin
      drive_elem(16'sd128, 16'sd0);
      if (e == 7) lastdrv[0] = cyc;
    end
    repeat (4) idle_cycle();
    check("q0_count", mcount - base, 1);
    check("q0_metric_q", mq[base], 0);
    check("q0_metric_out", mv[base], 512);
    check("q0_latency", mstamp[base] - lastdrv[0], 2);
    for (int k = 0; k < 29; k++) drive_elem(16'sd128, 16'sd0);
    idle_cycle();
    #2 rst = 1'b1;
    #1;
    check("abort_metric_out", bus.metric_out, 0);
    check("abort_metric_q", bus.metric_q, 0);
    check("abort_metric_valid", bus.metric_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_best_q", bus.best_q, 0);
    check("abort_best_metric", bus.best_metric, 32'hFFFF_FFFF);
    check("abort_count", mcount - base, 4);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) idle_cycle();
    check("abort_no_partial", mcount - base, 4);

    // Elements outside S_ACCUM must be ignored.
    for (int k = 0; k < 3; k++) drive_elem(16'sd1000, 16'sd1000);
    idle_cycle();
    check("stray_no_metric", mcount - base, 4);
`ifdef HQ_METRIC_SYNC_CHECK_EN
    check("stray_protocol_err", bus.protocol_err, 1);
`else
    check("stray_protocol_err", bus.protocol_err, 0);
`endif

    run_pattern(0, 1'b0, 1'b0, base);
    check("p0_protocol_err", bus.protocol_err, 0);
    check_run(0, base, 4'd9, 32'd256);

    run_pattern(1, 1'b1, 1'b0, base);
    check_run(1, base, 4'd3, 32'd128);

    run_pattern(2, 1'b0, 1'b0, base);
    check_run(2, base, 4'd0, 32'd67108864);

`ifdef HQ_METRIC_SYNC_CHECK_EN
    run_pattern(0, 1'b0, 1'b1, base);
    check("perr_set_held", bus.protocol_err, 1);
    check("perr_datapath_best_q", bus.best_q, 9);
    start_run();
    check("perr_cleared", bus.protocol_err, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hq_metric_argmin.md
Name: hq_metric_argmin

Overview:
- Downstream consumer of the Hq = H·S_q stream produced by the matrix multiplier.
- Per codeword q (16 per run), accumulates the squared Frobenius norm of the 4x2 complex Hq matrix (8 elements, row-major i then j).
- Streams each per-q metric out and tracks the running minimum across all 16 codewords.
- Reports the winning q index and its metric to the detector back-end.

Parameters:
- Q, 8, fractional bits of the Hq_in fixed-point format.
- N, 16, width of Hq_in_r and Hq_in_i (signed).
- ACC_WIDTH, 32, unsigned metric width; must be at least 2N+4-Q.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; rising into S_IDLE begins a run.
- Hq_in_valid  in  1  element strobe from upstream.
- Hq_in_r  in  N  signed real part.
- Hq_in_i  in  N  signed imaginary part.
- hq_one_matrix_done  in  1  upstream end-of-matrix pulse; used only by the optional check.
- all_16_hq_done  in  1  upstream end-of-run level; used only by the optional check.
- busy  out  1  high in S_ACCUM and S_FLUSH.
- metric_valid  out  1  one-cycle pulse per completed q.
- metric_q  out  4  q index of metric_out.
- metric_out  out  ACC_WIDTH  ||Hq||² of that q.
- best_valid  out  1  one-cycle pulse at end of run.
- best_q  out  4  argmin q.
- best_metric  out  ACC_WIDTH  minimum metric.
- protocol_err  out  1  sticky framing error; see Optional Feature.

Behaviour:
- Reset (async): state S_IDLE; all counters and outputs 0; best_metric all-ones.
- FSM states: S_IDLE, S_ACCUM, S_FLUSH, S_DONE.
  - S_IDLE & start -> S_ACCUM. Clears elem_cnt, q_cnt and acc; best_metric = all-ones; best_q = 0.
  - S_ACCUM -> S_FLUSH when the 8th element of q=15 is accepted at stage 1.
  - S_FLUSH -> S_DONE when the q=15 metric is written.
  - S_DONE -> S_IDLE when start is low.
- Hq_in_valid is accepted only in S_ACCUM; it is ignored in every other state. start outside S_IDLE is ignored.
- Stage 1 (registered): sq = (r*r + i*i) >>> Q, unsigned, width 2N+1-Q. Valid and a last flag (elem_cnt==7) travel with it.
- Stage 2 (registered): acc <= last ? 0 : acc + sq.
  - On last: metric_out <= acc + sq, metric_q <= q_cnt, metric_valid <= 1 for one cycle, q_cnt increments.
  - No saturation is needed (max metric 8·2^(2N-1-Q) fits in ACC_WIDTH).
- Latency: metric_valid is high 2 cycles after the cycle in which the 8th element was presented.
- Min update happens on the same edge as the metric_out write: if (acc + sq) < best_metric, strict, then best_metric and best_q are updated. Ties keep the lower q.
- End of run: the best_valid pulse occurs on the cycle after the q=15 metric_valid. best_q and best_metric hold until the next start.
- Back-to-back elements (valid every cycle) are fully supported; gaps of any length are allowed.
- elem_cnt wraps 7->0; q_cnt wraps 15->0 on run end.
- Reset mid-run aborts immediately; no partial metric is emitted.

Optional Feature:
- Macro: HQ_METRIC_SYNC_CHECK_EN.
- Defined: protocol_err is set and held until the next start, on any of these:
  - hq_one_matrix_done asserted with a Hq_in_valid where elem_cnt != 7;
  - Hq_in_valid outside S_ACCUM;
  - all_16_hq_done seen while q_cnt != 0 or state is S_ACCUM.
  - Datapath behaviour is unchanged.
- Undefined: protocol_err is tied to 0 and the two upstream done inputs are unused.

Decomposition:
- Shared package hq_pkg holds:
  - Q, N and ACC_WIDTH defaults;
  - NUM_Q=16, ELEMS_PER_Q=8;
  - the FSM state encoding;
  - a metric_t typedef (unsigned ACC_WIDTH).
- One natural sub-module: cplx_mag_sq, the registered stage-1 squared-magnitude unit, reusable by other detector stages.

Test Plan:
- Single q=0 with 8 elements (128, 0) (=1.0) -> sq=64 each; metric_out=512, metric_q=0, metric_valid high 2 cycles after the 8th input.
- Full run with all elements (128, 0) except q=9 using (64, 64) -> q=9 metric = 8·32 = 256; best_q=9, best_metric=256; best_valid one cycle after the q=15 metric.
- Equal metrics for q=3 and q=7 (both minimum, 128) -> best_q=3.
- Extreme values (-32768, -32768) on all 128 elements -> each metric = 8·2^23 = 67108864, no overflow; best_q=0.
- Reset asserted after 5 elements of q=4 -> all outputs 0 asynchronously. A fresh start then yields a correct q=0 metric.
- With HQ_METRIC_SYNC_CHECK_EN: hq_one_matrix_done asserted on the 6th element -> protocol_err=1 and held; cleared on the next start.
